// File: rtl/alu_share_arb_if.sv
// rtl/alu_share_arb_if.sv - request, response and ALU-drive bundle for alu_share_arb
interface alu_share_arb_if;
    logic        req0_valid_i;
    logic        req0_ready_o;
    logic [31:0] req0_rs1_i;
    logic [31:0] req0_rs2_i;
    logic [3:0]  req0_sel_i;

    logic        req1_valid_i;
    logic        req1_ready_o;
    logic [31:0] req1_rs1_i;
    logic [31:0] req1_rs2_i;
    logic [3:0]  req1_sel_i;

    logic        rsp0_valid_o;
    logic [31:0] rsp0_data_o;
    logic        rsp0_ready_i;

    logic        rsp1_valid_o;
    logic [31:0] rsp1_data_o;
    logic        rsp1_ready_i;

    logic [31:0] alu_rs1_o;
    logic [31:0] alu_rs2_o;
    logic [3:0]  alu_sel_o;
    logic [31:0] alu_result_i;

    modport slave (
        input  req0_valid_i, req0_rs1_i, req0_rs2_i, req0_sel_i,
        input  req1_valid_i, req1_rs1_i, req1_rs2_i, req1_sel_i,
        input  rsp0_ready_i, rsp1_ready_i, alu_result_i,
        output req0_ready_o, req1_ready_o,
        output rsp0_valid_o, rsp0_data_o, rsp1_valid_o, rsp1_data_o,
        output alu_rs1_o, alu_rs2_o, alu_sel_o
    );

    modport master (
        output req0_valid_i, req0_rs1_i, req0_rs2_i, req0_sel_i,
        output req1_valid_i, req1_rs1_i, req1_rs2_i, req1_sel_i,
        output rsp0_ready_i, rsp1_ready_i, alu_result_i,
        input  req0_ready_o, req1_ready_o,
        input  rsp0_valid_o, rsp0_data_o, rsp1_valid_o, rsp1_data_o,
        input  alu_rs1_o, alu_rs2_o, alu_sel_o
    );
endinterface

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - two-requester ALU share arbiter with per-requester response slots
// Optional build macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins contention.
module alu_share_arb (
    input  logic           clk_i,
    input  logic           rst_ni,
    alu_share_arb_if.slave bus
);
    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    rsp_state_e  rsp0_state_q, rsp0_state_d;
    rsp_state_e  rsp1_state_q, rsp1_state_d;
    logic [31:0] rsp0_data_q, rsp0_data_d;
    logic [31:0] rsp1_data_q, rsp1_data_d;

    logic elig0;
    logic elig1;
    logic gnt0;
    logic gnt1;

    // A slot that drains this cycle can accept a new result on the same edge.
    assign elig0 = bus.req0_valid_i & ((rsp0_state_q == RSP_EMPTY) | bus.rsp0_ready_i);
    assign elig1 = bus.req1_valid_i & ((rsp1_state_q == RSP_EMPTY) | bus.rsp1_ready_i);

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt0 = elig0;
        gnt1 = elig1 & ~elig0;
    end
`else
    logic last_q, last_d;

    // last_q = 1 means requester 1 was served most recently, so 0 wins next.
    always_comb begin
        gnt0   = elig0 & (~elig1 | last_q);
        gnt1   = elig1 & (~elig0 | ~last_q);
        last_d = last_q;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_comb begin
        bus.alu_rs1_o = 32'd0;
        bus.alu_rs2_o = 32'd0;
        bus.alu_sel_o = 4'd0;
        if (gnt0) begin
            bus.alu_rs1_o = bus.req0_rs1_i;
            bus.alu_rs2_o = bus.req0_rs2_i;
            bus.alu_sel_o = bus.req0_sel_i;
        end else if (gnt1) begin
            bus.alu_rs1_o = bus.req1_rs1_i;
            bus.alu_rs2_o = bus.req1_rs2_i;
            bus.alu_sel_o = bus.req1_sel_i;
        end
    end

    always_comb begin
        rsp0_state_d = rsp0_state_q;
        rsp0_data_d  = rsp0_data_q;
        case (rsp0_state_q)
            RSP_EMPTY: begin
                if (gnt0) begin
                    rsp0_state_d = RSP_FULL;
                end
            end
            RSP_FULL: begin
                if (bus.rsp0_ready_i && !gnt0) begin
                    rsp0_state_d = RSP_EMPTY;
                end
            end
            default: rsp0_state_d = RSP_EMPTY;
        endcase
        if (gnt0) begin
            rsp0_data_d = bus.alu_result_i;
        end
    end

    always_comb begin
        rsp1_state_d = rsp1_state_q;
        rsp1_data_d  = rsp1_data_q;
        case (rsp1_state_q)
            RSP_EMPTY: begin
                if (gnt1) begin
                    rsp1_state_d = RSP_FULL;
                end
            end
            RSP_FULL: begin
                if (bus.rsp1_ready_i && !gnt1) begin
                    rsp1_state_d = RSP_EMPTY;
                end
            end
            default: rsp1_state_d = RSP_EMPTY;
        endcase
        if (gnt1) begin
            rsp1_data_d = bus.alu_result_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp0_state_q <= RSP_EMPTY;
            rsp1_state_q <= RSP_EMPTY;
            rsp0_data_q  <= 32'd0;
            rsp1_data_q  <= 32'd0;
        end else begin
            rsp0_state_q <= rsp0_state_d;
            rsp1_state_q <= rsp1_state_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
        end
    end

    assign bus.req0_ready_o = gnt0;
    assign bus.req1_ready_o = gnt1;
    assign bus.rsp0_valid_o = (rsp0_state_q == RSP_FULL);
    assign bus.rsp1_valid_o = (rsp1_state_q == RSP_FULL);
    assign bus.rsp0_data_o  = rsp0_data_q;
    assign bus.rsp1_data_o  = rsp1_data_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - scoreboard bench for alu_share_arb with a behavioural ALU
`timescale 1ns/1ps
module tb_alu_share_arb;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_share_arb_if bus();

    alu_share_arb dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    function automatic logic [31:0] alu_ref(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        case (sel)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    always_comb bus.alu_result_i = alu_ref(bus.alu_sel_o, bus.alu_rs1_o, bus.alu_rs2_o);

    int checks = 0;
    int failures = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    bit          p_valid [2];
    logic [31:0] p_rs1 [2];
    logic [31:0] p_rs2 [2];
    logic [3:0]  p_sel [2];
    bit          rsp_rdy [2];
    bit          pushed_now [2];
    int          last_m = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qsz(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic drive();
        bus.req0_valid_i = p_valid[0];
        bus.req0_rs1_i   = p_rs1[0];
        bus.req0_rs2_i   = p_rs2[0];
        bus.req0_sel_i   = p_sel[0];
        bus.req1_valid_i = p_valid[1];
        bus.req1_rs1_i   = p_rs1[1];
        bus.req1_rs2_i   = p_rs2[1];
        bus.req1_sel_i   = p_sel[1];
        bus.rsp0_ready_i = rsp_rdy[0];
        bus.rsp1_ready_i = rsp_rdy[1];
    endtask

    task automatic set_req(input int k, input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        p_valid[k] = 1'b1;
        p_sel[k]   = sel;
        p_rs1[k]   = a;
        p_rs2[k]   = b;
    endtask

    task automatic set_rand_req(input int k);
        set_req(k, 4'($urandom_range(0, 7)), $urandom, ($urandom % 2 == 0) ? $urandom : 32'($urandom_range(0, 40)));
    endtask

    // One cycle: drive at negedge, then judge the grant against the model before the rising edge.
    task automatic step();
        bit e0, e1;
        int w;
        logic [31:0] er1, er2, res;
        logic [3:0]  esel;
        @(negedge clk);
        drive();
        #3;
        e0 = p_valid[0] && (qsz(0) == 0 || rsp_rdy[0]);
        e1 = p_valid[1] && (qsz(1) == 0 || rsp_rdy[1]);
        w = -1;
        if (e0 && e1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            w = 0;
`else
            w = (last_m == 1) ? 0 : 1;
`endif
        end else if (e0) begin
            w = 0;
        end else if (e1) begin
            w = 1;
        end
        chk("req0_ready", 32'(bus.req0_ready_o), 32'(w == 0));
        chk("req1_ready", 32'(bus.req1_ready_o), 32'(w == 1));
        er1 = (w < 0) ? 32'd0 : p_rs1[w];
        er2 = (w < 0) ? 32'd0 : p_rs2[w];
        esel = (w < 0) ? 4'd0 : p_sel[w];
        chk("alu_rs1", bus.alu_rs1_o, er1);
        chk("alu_rs2", bus.alu_rs2_o, er2);
        chk("alu_sel", 32'(bus.alu_sel_o), 32'(esel));
        if (w >= 0) begin
            res = alu_ref(p_sel[w], p_rs1[w], p_rs2[w]);
            if (w == 0) q0.push_back(res); else q1.push_back(res);
            pushed_now[w] = 1'b1;
            p_valid[w] = 1'b0;
            last_m = w;
        end
    endtask

    task automatic wait_grant(input int k);
        int n;
        n = 0;
        while (p_valid[k] && n < 30) begin
            step();
            n++;
        end
        if (p_valid[k]) begin
            checks++;
            failures++;
            $display("FAIL grant_timeout req%0d: still pending after %0d cycles, required grant", k, n);
        end
    endtask

    // Response monitor: occupancy and data against the scoreboard queues.
    initial begin
        int occ;
        logic [31:0] expd;
        forever begin
            @(negedge clk);
            #4;
            occ = q0.size() - int'(pushed_now[0]);
            chk("rsp0_valid", 32'(bus.rsp0_valid_o), 32'(occ > 0));
            if (bus.rsp0_valid_o && occ > 0) begin
                expd = q0[0];
                chk("rsp0_data", bus.rsp0_data_o, expd);
                if (bus.rsp0_ready_i) void'(q0.pop_front());
            end
            occ = q1.size() - int'(pushed_now[1]);
            chk("rsp1_valid", 32'(bus.rsp1_valid_o), 32'(occ > 0));
            if (bus.rsp1_valid_o && occ > 0) begin
                expd = q1[0];
                chk("rsp1_data", bus.rsp1_data_o, expd);
                if (bus.rsp1_ready_i) void'(q1.pop_front());
            end
            pushed_now[0] = 1'b0;
            pushed_now[1] = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int k = 0; k < 2; k++) begin
            p_valid[k] = 1'b0; p_rs1[k] = 32'd0; p_rs2[k] = 32'd0; p_sel[k] = 4'd0;
            rsp_rdy[k] = 1'b1; pushed_now[k] = 1'b0;
        end
        drive();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset rsp0_valid", 32'(bus.rsp0_valid_o), 32'd0);
        chk("reset rsp1_valid", 32'(bus.rsp1_valid_o), 32'd0);
        chk("reset rsp0_data", bus.rsp0_data_o, 32'd0);
        chk("reset rsp1_data", bus.rsp1_data_o, 32'd0);
        #1 rst_n = 1'b1;

        // Contention straight out of reset: requester 0 first.
        set_req(0, OP_SUB, 32'd10, 32'd4);
        set_req(1, OP_XOR, 32'h0000_00F0, 32'h0000_000F);
        step();
        chk("first contention req0", 32'(bus.req0_ready_o), 32'd1);
        step();
        chk("contention rsp0", bus.rsp0_data_o, 32'd6);
        step();
        chk("contention rsp1", bus.rsp1_data_o, 32'h0000_00FF);

        for (int i = 0; i < 8; i++) begin
            if (!p_valid[0]) set_rand_req(0);
            if (!p_valid[1]) set_rand_req(1);
            step();
        end
        p_valid[0] = 1'b0;
        wait_grant(1);
        step();

        set_req(0, OP_ADD, 32'd5, 32'd3);
        step();
        step();
        chk("single rsp0_valid", 32'(bus.rsp0_valid_o), 32'd1);
        chk("single rsp0_data", bus.rsp0_data_o, 32'd8);

        for (int i = 1; i <= 4; i++) begin
            set_req(0, OP_ADD, 32'(i), 32'(i));
            step();
            if (i > 1) chk("b2b rsp0_data", bus.rsp0_data_o, 32'(2 * (i - 1)));
        end
        step();
        chk("b2b rsp0_data", bus.rsp0_data_o, 32'd8);

        // Backpressure on slot 1 while requester 0 keeps flowing.
        rsp_rdy[1] = 1'b0;
        set_req(1, OP_ADD, 32'd100, 32'd1);
        wait_grant(1);
        set_req(1, OP_SUB, 32'd50, 32'd8);
        for (int i = 0; i < 4; i++) begin
            set_rand_req(0);
            step();
            chk("bp req1_ready", 32'(bus.req1_ready_o), 32'd0);
            chk("bp req0_ready", 32'(bus.req0_ready_o), 32'd1);
            chk("bp rsp1_hold", bus.rsp1_data_o, 32'd101);
        end
        rsp_rdy[1] = 1'b1;
        step();
        chk("bp release req1", 32'(bus.req1_ready_o), 32'd1);
        step();
        chk("bp new rsp1", bus.rsp1_data_o, 32'd42);

        step();
        step();

        // Reset while both slots hold unconsumed results.
        rsp_rdy[0] = 1'b0;
        rsp_rdy[1] = 1'b0;
        set_req(0, OP_ADD, 32'h0000_1000, 32'h0000_0234);
        step();
        set_req(1, OP_XOR, 32'd1, 32'd2);
        step();
        @(posedge clk);
        #2;
        chk("pre-reset rsp0_data", bus.rsp0_data_o, 32'h0000_1234);
        rst_n = 1'b0;
        #1;
        chk("async rsp0_valid", 32'(bus.rsp0_valid_o), 32'd0);
        chk("async rsp1_valid", 32'(bus.rsp1_valid_o), 32'd0);
        chk("async rsp0_data", bus.rsp0_data_o, 32'd0);
        chk("async rsp1_data", bus.rsp1_data_o, 32'd0);
        q0.delete();
        q1.delete();
        last_m = 1;
        step();
        rst_n = 1'b1;
        rsp_rdy[0] = 1'b1;
        rsp_rdy[1] = 1'b1;
        set_req(0, OP_ADD, 32'd7, 32'd7);
        set_req(1, OP_ADD, 32'd9, 32'd9);
        step();
        chk("post-reset winner req0", 32'(bus.req0_ready_o), 32'd1);

        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (!p_valid[k] && ($urandom % 3 != 0)) set_rand_req(k);
                rsp_rdy[k] = ($urandom % 10) < 7;
            end
            step();
        end

        rsp_rdy[0] = 1'b1;
        rsp_rdy[1] = 1'b1;
        n = 0;
        while ((p_valid[0] || p_valid[1] || q0.size() != 0 || q1.size() != 0) && n < 40) begin
            step();
            n++;
        end
        if (p_valid[0] || p_valid[1] || q0.size() != 0 || q1.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: work outstanding after %0d cycles, required none", n);
        end
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester arbiter and response buffer that time-shares the single 32-bit R-type ALU between the integer execute path (requester 0) and the address/branch-compare path (requester 1). It selects at most one request per cycle and drives the chosen operands and select code onto the ALU. It captures the ALU result in a per-requester response register and returns it with a valid/ready handshake. The block sits between both requesters and the combinational ALU instance.

## Interface
- No parameters; data width is fixed at 32, select width at 4 (ALU select encoding from `define.sv`).
- clk_i  in  1  single clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- reqK_valid_i  in  1  request K (K=0,1) presents operands
- reqK_ready_o  out  1  request K granted this cycle
- reqK_rs1_i, reqK_rs2_i  in  32  operands for request K
- reqK_sel_i  in  4  ALU select code for request K
- rspK_valid_o  out  1  response K holds a result
- rspK_data_o  out  32  result for requester K
- rspK_ready_i  in  1  requester K accepts the response
- alu_rs1_o, alu_rs2_o  out  32  operands driven to ALU
- alu_sel_o  out  4  select driven to ALU
- alu_result_i  in  32  combinational ALU result

## Operation
- eligible_K = reqK_valid_i & (!rspK_valid_o | rspK_ready_i). A request is eligible only if its response slot is empty or drains in the same cycle.
- Grant: at most one reqK_ready_o is high per cycle, and only for an eligible requester. reqK_ready_o is combinational from the valids, the response state, rspK_ready_i and the pointer.
- Round-robin pointer `last` (1 bit) records the most recently granted requester.
  - If only one requester is eligible, it wins.
  - If both are eligible, the requester != last wins.
  - `last` updates only on a grant.
- ALU drive: the granted requester's rs1/rs2/sel are driven to the ALU. With no grant, all three outputs are 0.
- Capture: on a grant to K, rspK_data_o <= alu_result_i and rspK_valid_o <= 1.
- Drain: if rspK_ready_i & rspK_valid_o and there is no new grant to K, rspK_valid_o <= 0.
- Simultaneous drain and grant on K: valid stays 1 and data is replaced. This gives back-to-back throughput of one per cycle.
- rspK_data_o is stable while rspK_valid_o & !rspK_ready_i.
- The two response slots are independent. A stalled requester 1 never blocks requester 0.
- Requests are never dropped. reqK_valid_i must stay high with stable operands until reqK_ready_o.
- Per-requester state machine on rspK_valid_o: EMPTY -> FULL on grant; FULL -> EMPTY on drain without grant; FULL -> FULL on drain with grant, or on no drain.

## Timing
- Latency: grant in cycle N; rspK_valid_o is high and the data is valid in cycle N+1.
- Throughput: one ALU operation per cycle in aggregate.
- Reset values (asynchronous on rst_ni low):
  - rsp0_valid_o = rsp1_valid_o = 0
  - rsp0_data_o = rsp1_data_o = 0
  - last = 1, so requester 0 wins the first contention
- Reset asserted mid-transaction: pending responses are discarded immediately. Outputs take their reset values in the same cycle, without waiting for a clock edge.
- The first grant is possible in the first rising edge after rst_ni deasserts.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins when both are eligible. `last` is not implemented; requester 1 may starve.
- ALU_ARB_FIXED_PRIO_EN undefined (default): round-robin as above.
- Reset values and latency are identical in both builds.

## Test plan
- Single request: req0 sel=`ADD`, rs1=5, rs2=3, rsp0_ready_i=1 -> req0_ready_o=1 in cycle N; rsp0_valid_o=1 and rsp0_data_o=8 in cycle N+1.
- Contention after reset: both valid, req0 `SUB` 10,4 and req1 `XOR` 0xF0,0x0F, both rsp ready held -> req0 granted first (rsp0=6), req1 next cycle (rsp1=0xFF). Under continuous contention grants alternate 0,1,0,1. With ALU_ARB_FIXED_PRIO_EN, req0 is granted every cycle.
- Backpressure: rsp1_ready_i=0 with rsp1 full, req1 valid -> req1_ready_o=0. rsp1_data_o holds its value and req0 is still served each cycle. Raising rsp1_ready_i grants req1 in that same cycle.
- Back-to-back same requester: req0 valid for 4 cycles with `ADD` (1,1), (2,2), (3,3), (4,4), rsp0_ready_i=1 -> rsp0_data_o = 2, 4, 6, 8 on consecutive cycles; rsp0_valid_o stays 1.
- Idle ALU drive: no valid requests -> alu_rs1_o = alu_rs2_o = 0 and alu_sel_o = 0; rsp*_valid_o unchanged.
- Async reset mid-op: rsp0 full holding 0x1234 and rsp1_ready_i=0; pulse rst_ni low between clock edges -> both rsp valids and data are 0 immediately. The first post-reset contention grants req0.
